// File: rtl/syn_fifo_lvl.sv
// Purpose: single-clock FIFO with registered level, almost-full/empty thresholds and sticky overflow/underflow flags.
// Latency: 1-cycle read data in standard mode; 2-cycle write-to-visible in FWFT mode (build with SYN_FIFO_LVL_FWFT_EN).
// Backpressure: writes while full and reads while empty are dropped and flagged (ovf/udf); producer must honour full.
module syn_fifo_lvl #(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [ADDR_WIDTH:0]   afull_lvl,
    input  logic [ADDR_WIDTH:0]   aempty_lvl,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  alfull,
    output logic                  alempty,
    output logic                  ovf,
    output logic                  udf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

    // DLY only shapes simulation models of this block; register updates here carry no delay.
    if (ADDR_WIDTH < 1 || DLY < 0) begin : g_param_check
        $error("syn_fifo_lvl: ADDR_WIDTH must be >= 1 and DLY >= 0");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic flush;
    logic wr_acc;
    logic wr_rej;
    logic rd_acc;
    logic rd_rej;
    logic mem_rd;

    // rst and clr both flush; any request in a flushing cycle is ignored.
    assign flush  = rst | clr;
    // full is judged on the registered count, before this cycle's read.
    assign full   = (count_q == DEPTH_CNT);
    assign wr_acc = wen & ~full & ~flush;
    assign wr_rej = wen &  full & ~flush;

`ifdef SYN_FIFO_LVL_FWFT_EN
    logic out_vld;
    logic mem_empty;

    // Array is empty when both pointers, including the wrap bit, agree.
    assign mem_empty = (wr_ptr == rd_ptr);
    assign empty     = ~out_vld;
    assign rd_acc    = ren &  out_vld & ~flush;
    assign rd_rej    = ren & ~out_vld & ~flush;
    // Prefetch whenever the output stage is free or being consumed this cycle.
    assign mem_rd    = ~mem_empty & (~out_vld | rd_acc) & ~flush;

    // Output stage: head word plus its valid bit; a flush in FWFT mode also clears the word.
    always_ff @(posedge clk) begin
        if (flush) begin
            dout_q  <= '0;
            out_vld <= 1'b0;
        end else if (mem_rd) begin
            dout_q  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            out_vld <= 1'b1;
        end else if (rd_acc) begin
            out_vld <= 1'b0;
        end
    end
`else
    assign empty  = (count_q == '0);
    assign rd_acc = ren & ~empty & ~flush;
    assign rd_rej = ren &  empty & ~flush;
    assign mem_rd = rd_acc;

    // Read register: rst zeroes it, clr leaves the last word visible, a rejected read leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (!clr && mem_rd) begin
            dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end
`endif

    // Storage array: written on accepted writes only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    // Pointers wrap naturally modulo 2^(ADDR_WIDTH+1).
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy counts every held word, including one parked in the FWFT output stage.
    always_ff @(posedge clk) begin
        if (flush) begin
            count_q <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags, cleared only by a flush.
    always_ff @(posedge clk) begin
        if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | wr_rej;
            udf_q <= udf_q | rd_rej;
        end
    end

    assign dout    = dout_q;
    assign count   = count_q;
    assign alfull  = (count_q >= afull_lvl);
    assign alempty = (count_q <= aempty_lvl);
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule
